// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC sequencer.
//   mac_seq_state_t : sequencer FSM states
//   PERF_W          : width of the optional completed-result counter
package mac_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } mac_seq_state_t;

    localparam int unsigned PERF_W = 16;

endpackage

// File: rtl/mac_seq_addr_gen.sv
// Operand address generator: holds the base address and a loadable index counter
// and presents base + idx (mod 2**ADDR_W) as the read address.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture base_i and clear the index
//   base_i        : first operand address
//   inc_i         : advance the index by one
//   idx_o         : current index (LEN_W+1 bits so a full-length run never wraps)
//   addr_o        : base + idx, wrapping in the address space
module mac_seq_addr_gen #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic              inc_i,
    output logic [LEN_W:0]    idx_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W:0]    idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            base_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            base_q <= base_i;
            idx_q  <= '0;
        end else if (inc_i) begin
            idx_q <= idx_q + (LEN_W + 1)'(1);
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = base_q + ADDR_W'(idx_q);

endmodule

// File: rtl/mac_seq.sv
// MAC sequencer: on an accepted start, clears the MAC, streams len operand reads
// from a 1-cycle-latency memory, pulses mac_en in step with the returned data and
// then holds the result under a valid/ready handshake.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   start_i, start_rdy_o : command handshake (ready only in IDLE)
//   base_addr_i, len_i   : command fields, sampled on accept
//   busy_o               : high outside IDLE
//   rd_en_o, rd_addr_o   : operand memory read port
//   mac_clr_o, mac_en_o  : MAC clear / accumulate enable
//   res_valid_o, res_ready_i : result handshake
//   perf_ops_o           : completed-result count, only with MAC_SEQ_PERF_EN
// Optional feature macro: MAC_SEQ_PERF_EN
module mac_seq
    import mac_pkg::*;
#(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    output logic              start_rdy_o,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    output logic              busy_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic              mac_clr_o,
    output logic              mac_en_o,
    output logic              res_valid_o,
    input  logic              res_ready_i
`ifdef MAC_SEQ_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_ops_o
`endif
);

    mac_seq_state_t   state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic             mac_en_q;
    logic             accept;
    logic             rd_en;
    logic             mac_clr;
    logic [LEN_W:0]   idx;

    assign accept = (state_q == IDLE) && start_i;

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        mac_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) state_d = CLEAR;
            end
            CLEAR: begin
                mac_clr = 1'b1;
                if (len_q != '0) begin
                    rd_en   = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = DONE;
                end
            end
            RUN: begin
                // Once all reads are issued, this cycle carries the last mac_en.
                if (idx < {1'b0, len_q}) begin
                    rd_en = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (res_ready_i) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            len_q    <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Data returns one cycle after the read strobe.
            mac_en_q <= rd_en;
            if (accept) len_q <= len_i;
        end
    end

    mac_seq_addr_gen #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_addr_gen (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .load_i(accept),
        .base_i(base_addr_i),
        .inc_i (rd_en),
        .idx_o (idx),
        .addr_o(rd_addr_o)
    );

    assign start_rdy_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rd_en_o     = rd_en;
    assign mac_clr_o   = mac_clr;
    assign mac_en_o    = mac_en_q;
    assign res_valid_o = (state_q == DONE);

`ifdef MAC_SEQ_PERF_EN
    logic [PERF_W-1:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if ((state_q == DONE) && res_ready_i && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_W'(1);
        end
    end

    assign perf_ops_o = perf_q;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq: stimulus pushes expected read/clear/enable/result
// cycles into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_mac_seq;
    import mac_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       res_ready = 1'b1;
    logic [3:0] base = '0;
    logic [4:0] len = '0;
    logic       start_rdy, busy, rd_en, mac_clr, mac_en, res_valid;
    logic [3:0] rd_addr;
`ifdef MAC_SEQ_PERF_EN
    logic [15:0] perf_ops;
`endif

    mac_seq #(
        .ADDR_W(4),
        .LEN_W (5)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .start_rdy_o(start_rdy),
        .base_addr_i(base),
        .len_i      (len),
        .busy_o     (busy),
        .rd_en_o    (rd_en),
        .rd_addr_o  (rd_addr),
        .mac_clr_o  (mac_clr),
        .mac_en_o   (mac_en),
        .res_valid_o(res_valid),
        .res_ready_i(res_ready)
`ifdef MAC_SEQ_PERF_EN
        ,
        .perf_ops_o (perf_ops)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass = 0;
    int ops_done = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int c;
        int a;
    } rd_t;

    rd_t exp_rd[$];
    int  exp_mac[$];
    int  exp_clr[$];
    int  exp_res[$];
    logic prev_valid = 1'b0;

    // Monitor: runs at negedge, stimulus changes inputs at negedge+2.
    always @(negedge clk) begin
        rd_t e;
        int  x;
        if (rd_en) begin
            if (exp_rd.size() == 0) check("rd_extra", int'(rd_en), 0);
            else begin
                e = exp_rd.pop_front();
                check("rd_cycle", cyc, e.c);
                check("rd_addr", int'(rd_addr), e.a);
            end
        end
        if (mac_en) begin
            if (exp_mac.size() == 0) check("mac_en_extra", int'(mac_en), 0);
            else begin
                x = exp_mac.pop_front();
                check("mac_en_cycle", cyc, x);
            end
        end
        if (mac_clr) begin
            if (exp_clr.size() == 0) check("mac_clr_extra", int'(mac_clr), 0);
            else begin
                x = exp_clr.pop_front();
                check("mac_clr_cycle", cyc, x);
            end
        end
        if (res_valid && !prev_valid) begin
            if (exp_res.size() == 0) check("res_valid_extra", int'(res_valid), 0);
            else begin
                x = exp_res.pop_front();
                check("res_valid_cycle", cyc, x);
            end
        end
        if (res_valid && res_ready) ops_done <= ops_done + 1;
        prev_valid <= res_valid;
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        #2;
        while (!start_rdy && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!start_rdy) check("idle_timeout", int'(start_rdy), 1);
    endtask

    task automatic issue(input int b, input int l);
        int c;
        wait_idle();
        base  = 4'(b);
        len   = 5'(l);
        start = 1'b1;
        c     = cyc;
        exp_clr.push_back(c + 1);
        for (int i = 0; i < l; i++) begin
            rd_t e;
            e.c = c + 1 + i;
            e.a = (b + i) % 16;
            exp_rd.push_back(e);
            exp_mac.push_back(c + 2 + i);
        end
        exp_res.push_back(c + l + 2);
        @(negedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!res_valid) check("valid_timeout", int'(res_valid), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start_rdy"}, int'(start_rdy), 1);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
        check({tag, "_mac_clr"}, int'(mac_clr), 0);
        check({tag, "_mac_en"}, int'(mac_en), 0);
        check({tag, "_res_valid"}, int'(res_valid), 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // 1: basic run
        issue(3, 4);
        // 2: zero length
        issue(0, 0);
        // 3: address wrap
        issue(14, 4);
        // full length: idx must not wrap
        issue(7, 31);

        // 4: back-pressure in DONE, start ignored while busy and on handshake
        wait_idle();
        res_ready = 1'b0;
        issue(5, 2);
        wait_valid();
        base  = 4'd9;
        len   = 5'd3;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_res_valid", int'(res_valid), 1);
            check("hold_mac_en", int'(mac_en), 0);
            check("hold_start_rdy", int'(start_rdy), 0);
            check("hold_busy", int'(busy), 1);
            @(negedge clk);
            #2;
        end
        res_ready = 1'b1;
        @(negedge clk);
        #2;
        start = 1'b0;
        check("after_hs_start_rdy", int'(start_rdy), 1);
        issue(0, 1);

        // 5: reset in RUN cycle 3
        issue(3, 4);
        @(negedge clk);
        #2;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_rd.delete();
        exp_mac.delete();
        exp_clr.delete();
        exp_res.delete();
        ops_done = 0;
        #1 check_reset_outputs("midrun_reset");
        @(negedge clk);
        #2;
        check_reset_outputs("held_reset");
        rst_n = 1'b1;
        issue(3, 4);

`ifdef MAC_SEQ_PERF_EN
        // 6: perf counter
        issue(1, 2);
        issue(2, 0);
        wait_idle();
        check("perf_ops_count", int'(perf_ops), ops_done);
        check("perf_ops_three", int'(perf_ops), 3);
        force dut.perf_q = 16'hFFFF;
        #1 release dut.perf_q;
        issue(4, 1);
        wait_idle();
        check("perf_ops_saturate", int'(perf_ops), 32'hFFFF);
`endif

        wait_idle();
        repeat (3) @(negedge clk);
        #2;
        check("rd_left", exp_rd.size(), 0);
        check("mac_en_left", exp_mac.size(), 0);
        check("mac_clr_left", exp_clr.size(), 0);
        check("res_left", exp_res.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
